// File: rtl/radix_bist_checker.sv
// radix_bist_checker: sequences a BIST run of the radix-4 multiplier and checks its MISR signature against a golden value
module radix_bist_checker #(
  parameter logic [15:0] GOLDEN_SIG  = 16'h0000,
  parameter int          TEST_CYCLES = 1024,
  parameter int          TIMEOUT     = 256,
  parameter int          CNT_W       = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic        abort,
  input  logic [15:0] sig_in,
  input  logic        sig_ready,
  output logic        active_test,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] signature
);
  typedef enum logic [2:0] {IDLE, RUN, WAIT, CHECK, DONE} state_t;
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(TEST_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
  state_t nxt, state;
  logic [CNT_W-1:0] cnt;
  logic rdy_q, rdy_ok;
  // ready counts only when high on this WAIT sample and the previous one
  assign rdy_ok = rdy_q & sig_ready;
  assign busy = state inside {RUN, WAIT, CHECK};
  assign active_test = busy;
  assign done = state == DONE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = run ? RUN : IDLE;
      RUN:     nxt = cnt == RUN_LAST ? WAIT : RUN;
      WAIT:    nxt = rdy_ok ? CHECK : cnt == WAIT_LAST ? DONE : WAIT;
      CHECK:   nxt = DONE;
      DONE:    nxt = run ? RUN : DONE;
      default: nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rdy_q     <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      signature <= '0;
    end else begin
      state <= nxt;
      cnt   <= (nxt == state && (state == RUN || state == WAIT)) ? cnt + 1'b1 : '0;
      rdy_q <= (state == WAIT && nxt == WAIT) ? sig_ready : 1'b0;
      if (state == WAIT && nxt == CHECK) signature <= sig_in;
      if (state == WAIT && nxt == DONE) begin
        timeout   <= 1'b1;
        signature <= '0;
      end
      if (state == CHECK && nxt == DONE) pass <= signature == GOLDEN_SIG;
      if (nxt == IDLE || (nxt == RUN && state != RUN)) begin
        pass    <= 1'b0;
        timeout <= 1'b0;
      end
    end
  end
endmodule
